paralelo_serial_tx: RTL and testbench

//   Transmit end of the serial link: takes parallel bytes and drives them MSB-first on a 1-bit line.

---
 rtl/paralelo_serial_tx.sv | 85 ++++++++
 tb/tb_paralelo_serial_tx.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/paralelo_serial_tx.sv
// paralelo_serial_tx: MSB-first byte serialiser on the bit clock, sends training commas after reset, then data or filler.
// Option PARALELO_SERIAL_COMMA_FILL_EN: empty slots carry COMMA_BYTE instead of IDLE_BYTE. Rev 1.0
`default_nettype none

module paralelo_serial_tx #(
  parameter logic [7:0]  COMMA_BYTE  = 8'hBC,
  parameter logic [7:0]  IDLE_BYTE   = 8'h7C,
  parameter int unsigned COMMA_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       in_ready,
  output logic       data_out,
  output logic       active,
  output logic       byte_sync
);

  localparam logic [0:0] c_TRAIN      = 1'b0;
  localparam logic [0:0] c_ACTIVE     = 1'b1;
  localparam logic [7:0] c_LAST_COMMA = 8'(COMMA_COUNT - 1);
`ifdef PARALELO_SERIAL_COMMA_FILL_EN
  localparam logic [7:0] c_FILL       = COMMA_BYTE;
`else
  localparam logic [7:0] c_FILL       = IDLE_BYTE;
`endif

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_comma_cnt;
  logic [7:0] r_shift;
  logic       w_boundary;
  logic       w_last_comma;
  logic [7:0] w_next_byte;

  assign w_boundary   = (r_bit_cnt == 3'd7);
  assign w_last_comma = (r_comma_cnt == c_LAST_COMMA);

  always_ff @(posedge clk_32f) begin
    if (reset) r_state <= c_TRAIN;
    else       r_state <= w_state_nxt;
  end

  // Leave training on the boundary that loads the first data slot, so no gap follows the commas.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == c_TRAIN && w_boundary && w_last_comma)
      w_state_nxt = c_ACTIVE;
  end

  always_comb begin
    in_ready  = w_boundary && (r_state == c_ACTIVE || w_last_comma);
    data_out  = r_shift[7];
    active    = (r_state == c_ACTIVE);
    byte_sync = (r_bit_cnt == 3'd0);
  end

  always_comb begin
    w_next_byte = COMMA_BYTE;
    if (in_ready)
      w_next_byte = valid_in ? data_in : c_FILL;
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_bit_cnt   <= 3'd0;
      r_comma_cnt <= 8'd0;
      r_shift     <= COMMA_BYTE;
    end else begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_boundary) begin
        r_shift <= w_next_byte;
        if (r_state == c_TRAIN)
          r_comma_cnt <= r_comma_cnt + 8'd1;
      end else begin
        r_shift <= {r_shift[6:0], 1'b0};
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_paralelo_serial_tx.sv
// tb_paralelo_serial_tx: directed checks of training, streaming, filler, handshake and mid-byte reset.
`default_nettype none

module tb_paralelo_serial_tx;

  localparam logic [7:0] c_COMMA = 8'hBC;
`ifdef PARALELO_SERIAL_COMMA_FILL_EN
  localparam logic [7:0] c_FILL  = 8'hBC;
`else
  localparam logic [7:0] c_FILL  = 8'h7C;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       in_ready;
  logic       data_out;
  logic       active;
  logic       byte_sync;

  int n_checks = 0;
  int n_errors = 0;

  paralelo_serial_tx dut (
    .clk_32f   (clk),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .active    (active),
    .byte_sync (byte_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rst_dout"},  32'(data_out),  32'd1);
    check_val({tag, "_rst_act"},   32'(active),    32'd0);
    check_val({tag, "_rst_sync"},  32'(byte_sync), 32'd1);
    check_val({tag, "_rst_rdy"},   32'(in_ready),  32'd0);
  endtask

  // Holds reset for 3 edges; returns just after the last reset edge, so the next negedge is cycle 0.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs(tag);
    reset = 1'b0;
  endtask

  task automatic expect_byte(input logic [7:0] b, input logic act, input logic rdy_last,
                             input int nb, input string tag);
    logic [7:0] v;
    v = b;
    for (int k = 0; k < nb; k++) begin
      @(negedge clk);
      check_val($sformatf("%s_b%0d_dout", tag, k), 32'(data_out),  32'(v[7-k]));
      check_val($sformatf("%s_b%0d_sync", tag, k), 32'(byte_sync), 32'(k == 0));
      check_val($sformatf("%s_b%0d_act",  tag, k), 32'(active),    32'(act));
      check_val($sformatf("%s_b%0d_rdy",  tag, k), 32'(in_ready),  32'((k == 7) && rdy_last));
    end
  endtask

  task automatic expect_training(input string tag);
    for (int c = 0; c < 3; c++)
      expect_byte(c_COMMA, 1'b0, 1'b0, 8, $sformatf("%s_comma%0d", tag, c));
    expect_byte(c_COMMA, 1'b0, 1'b1, 8, {tag, "_comma3"});
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;

    // Idle after training: commas then filler slots.
    do_reset("t1");
    expect_training("t1");
    expect_byte(c_FILL, 1'b1, 1'b1, 8, "t1_fill0");
    expect_byte(c_FILL, 1'b1, 1'b1, 8, "t1_fill1");

    // Byte offered from reset is taken only at the last comma boundary.
    valid_in = 1'b1;
    data_in  = 8'hA5;
    do_reset("t2");
    expect_training("t2");
    expect_byte(8'hA5, 1'b1, 1'b1, 8, "t2_d0");
    expect_byte(8'hA5, 1'b1, 1'b1, 8, "t2_d1");

    // Back-to-back stream with no filler between bytes.
    valid_in = 1'b1;
    data_in  = 8'h01;
    do_reset("t3");
    expect_training("t3");
    @(posedge clk); #1 data_in = 8'h02;
    expect_byte(8'h01, 1'b1, 1'b1, 8, "t3_d1");
    @(posedge clk); #1 data_in = 8'h03;
    expect_byte(8'h02, 1'b1, 1'b1, 8, "t3_d2");
    @(posedge clk); #1 valid_in = 1'b0;
    expect_byte(8'h03, 1'b1, 1'b1, 8, "t3_d3");
    expect_byte(c_FILL, 1'b1, 1'b1, 8, "t3_fill");

    // One empty slot: filler goes out and the held byte waits.
    valid_in = 1'b1;
    data_in  = 8'h3C;
    do_reset("t4");
    expect_training("t4");
    @(posedge clk); #1 begin valid_in = 1'b0; data_in = 8'hC3; end
    expect_byte(8'h3C, 1'b1, 1'b1, 8, "t4_d0");
    @(posedge clk); #1 valid_in = 1'b1;
    expect_byte(c_FILL, 1'b1, 1'b1, 8, "t4_gap");
    expect_byte(8'hC3, 1'b1, 1'b1, 8, "t4_d1");

    // Reset in the middle of a data byte restarts training; data resumes after the commas.
    valid_in = 1'b1;
    data_in  = 8'h5A;
    do_reset("t5");
    expect_training("t5");
    expect_byte(8'h5A, 1'b1, 1'b0, 4, "t5_part");
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("t5_mid");
    reset = 1'b0;
    expect_training("t5_re");
    expect_byte(8'h5A, 1'b1, 1'b1, 8, "t5_d");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
